// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store control stage:
// FSM states, fault codes, RISC-V funct3 values and cache load-type encodings.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LBU = 3'b001;
  localparam logic [2:0] LT_LH  = 3'b010;
  localparam logic [2:0] LT_LHU = 3'b011;
  localparam logic [2:0] LT_LW  = 3'b100;

endpackage

// File: rtl/lsu_decode.sv
// Combinational request classifier: funct3 -> cache strobe / load type, plus fault code.
// Misaligned trapping is only built when LSU_MISALIGN_TRAP_EN is defined.
module lsu_decode
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  output logic [3:0]  strobe,
  output logic [2:0]  load_type,
  output logic [1:0]  fault
);

  logic illegal;
  logic out_of_range;
  logic misaligned;
  logic unused_addr_lo;

  always_comb begin
    strobe    = 4'b0000;
    load_type = LT_LB;
    illegal   = 1'b0;
    if (store) begin
      case (funct3)
        F3_B:    strobe = 4'b0001;
        F3_H:    strobe = 4'b0011;
        F3_W:    strobe = 4'b1111;
        default: illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B:    load_type = LT_LB;
        F3_BU:   load_type = LT_LBU;
        F3_H:    load_type = LT_LH;
        F3_HU:   load_type = LT_LHU;
        F3_W:    load_type = LT_LW;
        default: illegal = 1'b1;
      endcase
    end
  end

  // Range is judged on the full address, before truncation to the cache width.
  assign out_of_range = |addr[31:ADDR_WIDTH];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign unused_addr_lo = ^addr[ADDR_WIDTH-1:0];

  assign fault = illegal      ? FAULT_ILLEGAL :
                 out_of_range ? FAULT_RANGE   :
                 misaligned   ? FAULT_MISALIGN : FAULT_NONE;

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage: one request at a time, one registered cache access, then a held
// response. Build option LSU_MISALIGN_TRAP_EN (see lsu_decode) turns misalignment into fault 01.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [1:0]            resp_fault,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  output logic [3:0]            cache_strobe,
  output logic                  cache_write_en,
  output logic                  cache_read_en,
  output logic [2:0]            cache_load_type,
  input  logic [DATA_WIDTH-1:0] cache_rdata,
  output logic                  busy
);

  lsu_state_e            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [3:0]            strobe_reg;
  logic [2:0]            load_type_reg;
  logic                  store_reg;
  logic [1:0]            fault_reg;

  logic [3:0] dec_strobe;
  logic [2:0] dec_load_type;
  logic [1:0] dec_fault;
  logic       req_fire;

  lsu_decode #(.ADDR_WIDTH(ADDR_WIDTH)) u_decode (
    .store     (req_store),
    .funct3    (req_funct3),
    .addr      (req_addr),
    .strobe    (dec_strobe),
    .load_type (dec_load_type),
    .fault     (dec_fault)
  );

  assign req_fire = req_valid && (state_reg == ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (req_fire) state_next = (dec_fault != FAULT_NONE) ? ST_RESP : ST_ACCESS;
      ST_ACCESS: state_next = ST_RESP;
      ST_RESP:   if (resp_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      strobe_reg    <= '0;
      load_type_reg <= '0;
      store_reg     <= 1'b0;
      fault_reg     <= FAULT_NONE;
    end else begin
      case (state_reg)
        ST_IDLE: if (req_fire) begin
          addr_reg      <= req_addr[ADDR_WIDTH-1:0];
          wdata_reg     <= req_wdata;
          strobe_reg    <= dec_strobe;
          load_type_reg <= dec_load_type;
          store_reg     <= req_store;
          fault_reg     <= dec_fault;
          rdata_reg     <= '0;
        end
        ST_ACCESS: rdata_reg <= store_reg ? '0 : cache_rdata;
        default: ;
      endcase
    end
  end

  // Cache and response outputs are qualified by state so they read 0 whenever idle.
  always_comb begin
    req_ready       = (state_reg == ST_IDLE);
    busy            = (state_reg != ST_IDLE);
    resp_valid      = 1'b0;
    resp_rdata      = '0;
    resp_fault      = FAULT_NONE;
    cache_addr      = '0;
    cache_wdata     = '0;
    cache_strobe    = 4'b0000;
    cache_write_en  = 1'b0;
    cache_read_en   = 1'b0;
    cache_load_type = 3'b000;
    case (state_reg)
      ST_ACCESS: begin
        cache_addr      = addr_reg;
        cache_wdata     = wdata_reg;
        cache_strobe    = strobe_reg;
        cache_write_en  = store_reg;
        cache_read_en   = !store_reg;
        cache_load_type = store_reg ? 3'b000 : load_type_reg;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_reg;
        resp_fault = fault_reg;
      end
      default: ;
    endcase
  end

endmodule
